// File: rtl/mips_boot_pkg.sv
// rtl/mips_boot_pkg.sv - shared states and constants for the MIPS boot loader
package mips_boot_pkg;

   typedef enum logic [2:0] {
      HDR_HI,
      HDR_LO,
      PAYLOAD,
      CHECK,
      DONE,
      ERR
   } boot_state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int HDR_BYTES      = 2;

   // States in which the loader consumes frame bytes
   function automatic logic state_accepts(input boot_state_t s);
      return (s == HDR_HI) || (s == HDR_LO) || (s == PAYLOAD) || (s == CHECK);
   endfunction

endpackage

// File: rtl/mips_boot_loader_byte_packer.sv
// rtl/mips_boot_loader_byte_packer.sv - big-endian byte-to-word assembler
module mips_boot_byte_packer
   import mips_boot_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  restart,
   input  logic                  accept,
   input  logic [7:0]            byte_in,
   output logic [DATA_WIDTH-1:0] word_next,
   output logic                  word_complete
);

   logic [1:0]            byte_cnt;
   // Only the three leading bytes need storage; the fourth arrives with word_complete
   logic [DATA_WIDTH-9:0] shift_q;

   assign word_next     = {shift_q, byte_in};
   assign word_complete = accept && (byte_cnt == 2'(BYTES_PER_WORD - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_cnt <= '0;
         shift_q  <= '0;
      end else if (restart) begin
         byte_cnt <= '0;
         shift_q  <= '0;
      end else if (accept) begin
         byte_cnt <= byte_cnt + 2'd1;
         shift_q  <= word_next[DATA_WIDTH-9:0];
      end
   end

endmodule

// File: rtl/mips_boot_loader.sv
// rtl/mips_boot_loader.sv - framed byte-serial image loader holding the core in reset
module mips_boot_loader
   import mips_boot_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_WORDS  = 256
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [7:0]            byte_in,
   input  logic                  byte_valid,
   output logic                  byte_ready,
   input  logic                  restart,
   output logic                  imem_wr_en,
   output logic [ADDR_WIDTH-1:0] imem_wr_addr,
   output logic [DATA_WIDTH-1:0] imem_wr_data,
   output logic                  core_rst,
   output logic                  done,
   output logic                  error
);

   localparam int          IDX_W = $clog2(MAX_WORDS + 1);
   localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

   boot_state_t           state, state_next;
   logic                  accept;
   logic                  pay_accept;
   logic [7:0]            hdr_hi;
   logic [15:0]           hdr_n;
   logic [15:0]           word_count;
   logic [IDX_W-1:0]      word_index;
   logic [7:0]            xor_acc;
   logic [DATA_WIDTH-1:0] word_next;
   logic                  word_complete;
   logic                  last_word;

   // Restart wins over a coincident byte, which is therefore never accepted
   assign accept     = byte_valid && byte_ready && !restart;
   assign pay_accept = accept && (state == PAYLOAD);
   assign hdr_n      = {hdr_hi, byte_in};
   assign last_word  = (16'(word_index) + 16'd1) == word_count;

   assign core_rst = (state != DONE);
   assign done     = (state == DONE);
   assign error    = (state == ERR);

   mips_boot_byte_packer #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_packer (
      .clk          (CLK),
      .rst          (RST),
      .restart      (restart),
      .accept       (pay_accept),
      .byte_in      (byte_in),
      .word_next    (word_next),
      .word_complete(word_complete)
   );

   always_comb begin
      state_next = state;
      if (restart) begin
         state_next = HDR_HI;
      end else begin
         case (state)
            HDR_HI:  if (accept) state_next = HDR_LO;
            HDR_LO: begin
               if (accept) begin
                  if ((hdr_n == 16'd0) || ({1'b0, hdr_n} > MAX_N)) state_next = ERR;
                  else                                             state_next = PAYLOAD;
               end
            end
            PAYLOAD: if (word_complete && last_word) state_next = CHECK;
            CHECK: begin
               if (accept) state_next = (byte_in == xor_acc) ? DONE : ERR;
            end
            default: state_next = state;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state        <= HDR_HI;
         byte_ready   <= 1'b0;
         hdr_hi       <= '0;
         word_count   <= '0;
         word_index   <= '0;
         xor_acc      <= '0;
         imem_wr_en   <= 1'b0;
         imem_wr_addr <= '0;
         imem_wr_data <= '0;
      end else begin
         state      <= state_next;
         byte_ready <= state_accepts(state_next);
         imem_wr_en <= 1'b0;
         // A completed word always writes, even if restart lands on the following cycle
         if (word_complete) begin
            imem_wr_en   <= 1'b1;
            imem_wr_addr <= ADDR_WIDTH'(word_index) << 2;
            imem_wr_data <= word_next;
         end
         if (restart) begin
            word_index <= '0;
            xor_acc    <= '0;
         end else if (accept) begin
            case (state)
               HDR_HI:  hdr_hi     <= byte_in;
               HDR_LO:  word_count <= hdr_n;
               PAYLOAD: begin
                  xor_acc <= xor_acc ^ byte_in;
                  if (word_complete) word_index <= word_index + 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
